// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types for the sequential magnitude comparator.
//
// Contents:
//   NIB_W       - width of one scanned digit (a hex nibble)
//   cmp_state_e - controller states IDLE / SCAN / DONE
//   cmp_res_t   - one-hot compare result {eq, gt, lt}
// -----------------------------------------------------------------------------
package cmp_pkg;

    // The datapath walks the operands one hex digit at a time.
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Result flags; exactly one bit is set whenever a result is presented.
    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

endpackage : cmp_pkg

// File: rtl/comparator_4bit.sv
// -----------------------------------------------------------------------------
// comparator_4bit
// Purely combinational unsigned compare of two 4-bit digits.
//
// Ports:
//   i_a, i_b   - digits to compare
//   o_equal    - i_a == i_b
//   o_larger   - i_a >  i_b
//   o_smaller  - i_a <  i_b
// -----------------------------------------------------------------------------
module comparator_4bit
    import cmp_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    output logic             o_equal,
    output logic             o_larger,
    output logic             o_smaller
);

    assign o_equal   = (i_a == i_b);
    assign o_larger  = (i_a >  i_b);
    assign o_smaller = (i_a <  i_b);

endmodule : comparator_4bit

// File: rtl/seq_mag_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mag_comparator_ctrl
// Multi-cycle magnitude comparator. One shared 4-bit comparator scans the
// captured operands from the most significant nibble downward, one nibble per
// clock, and stops at the first nibble that differs. Signed operands are
// handled by flipping the sign bit of both operands on capture, which maps
// two's-complement ordering onto unsigned ordering.
//
// Ports:
//   i_clk        - clock, all state updates on the rising edge
//   i_rst        - synchronous active-high reset
//   i_in_valid   - operand pair valid
//   o_in_ready   - block can accept an operand pair (IDLE and no flush)
//   i_in_a       - operand A
//   i_in_b       - operand B
//   i_in_signed  - 1 = two's-complement compare, 0 = unsigned
//   i_flush      - synchronous abort of the operation in progress
//   o_out_valid  - result valid (held until i_out_ready)
//   i_out_ready  - consumer accepts the result
//   o_out_eq     - A == B
//   o_out_gt     - A >  B
//   o_out_lt     - A <  B
//   o_busy       - an operation is in SCAN or DONE
// -----------------------------------------------------------------------------
module seq_mag_comparator_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic             i_in_signed,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_eq,
    output logic             o_out_gt,
    output logic             o_out_lt,
    output logic             o_busy
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIBS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBS - 1);

    // Operands must split into whole nibbles and span at least two of them.
    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_widthCheck
            $error("seq_mag_comparator_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    cmp_state_e                       r_state;
    cmp_state_e                       w_nextState;
    logic [NIBS-1:0][NIB_W-1:0]       r_opA;
    logic [NIBS-1:0][NIB_W-1:0]       r_opB;
    logic [IDX_W-1:0]                 r_nibIdx;
    cmp_res_t                         r_res;

    logic [WIDTH-1:0]                 w_biasA;
    logic [WIDTH-1:0]                 w_biasB;
    logic [NIB_W-1:0]                 w_nibA;
    logic [NIB_W-1:0]                 w_nibB;
    logic                             w_nibEq;
    logic                             w_nibGt;
    logic                             w_nibLt;
    logic                             w_accept;
    logic                             w_lastNib;

    // Flipping the sign bit turns two's-complement order into unsigned order,
    // so the scan logic never needs to know about signedness; the signed flag
    // therefore lives on only in the biased operand bits.
    assign w_biasA = {i_in_a[WIDTH-1] ^ i_in_signed, i_in_a[WIDTH-2:0]};
    assign w_biasB = {i_in_b[WIDTH-1] ^ i_in_signed, i_in_b[WIDTH-2:0]};

    assign w_nibA    = r_opA[r_nibIdx];
    assign w_nibB    = r_opB[r_nibIdx];
    assign w_lastNib = (r_nibIdx == '0);
    assign w_accept  = o_in_ready & i_in_valid;

    comparator_4bit u_nibCmp (
        .i_a       (w_nibA),
        .i_b       (w_nibB),
        .o_equal   (w_nibEq),
        .o_larger  (w_nibGt),
        .o_smaller (w_nibLt)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Flush aborts SCAN/DONE unconditionally; a SCAN step
    // ends the scan on the first differing nibble or after the last nibble.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (i_flush) begin
                    w_nextState = IDLE;
                end else if (w_nibGt || w_nibLt || (w_nibEq && w_lastNib)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (i_flush || i_out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode. in_ready depends only on state and flush, never on
    // out_ready, so no combinational path crosses the block.
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                o_in_ready = ~i_flush;
                o_busy     = 1'b0;
            end
            SCAN: begin
                o_busy = 1'b1;
            end
            DONE: begin
                o_out_valid = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_out_eq = r_res.eq;
    assign o_out_gt = r_res.gt;
    assign o_out_lt = r_res.lt;

    // Datapath: operand capture, nibble index walk and result latching.
    // The result flags are cleared on accept and only one is ever set per
    // operation, which keeps them one-hot while DONE presents them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_opA    <= '0;
            r_opB    <= '0;
            r_nibIdx <= IDX_TOP;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opA    <= w_biasA;
                        r_opB    <= w_biasB;
                        r_nibIdx <= IDX_TOP;
                        r_res    <= '0;
                    end
                end
                SCAN: begin
                    if (i_flush) begin
                        r_nibIdx <= IDX_TOP;
                        r_res    <= '0;
                    end else if (w_nibGt) begin
                        r_res.gt <= 1'b1;
                    end else if (w_nibLt) begin
                        r_res.lt <= 1'b1;
                    end else if (w_lastNib) begin
                        r_res.eq <= 1'b1;
                    end else begin
                        r_nibIdx <= r_nibIdx - 1'b1;
                    end
                end
                DONE: begin
                    if (i_flush) begin
                        r_nibIdx <= IDX_TOP;
                        r_res    <= '0;
                    end
                end
                default: begin
                    r_res <= '0;
                end
            endcase
        end
    end

    // A presented result is always exactly one of eq/gt/lt.
    a_resultOneHot : assert property (@(posedge i_clk) disable iff (i_rst)
        o_out_valid |-> $onehot({r_res.eq, r_res.gt, r_res.lt}));

    // No new operands may be accepted while an operation is in flight.
    a_noOverlap : assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_busy && o_in_ready));

    // A stalled result must not change under back-pressure.
    a_holdResult : assert property (@(posedge i_clk) disable iff (i_rst)
        (o_out_valid && !i_out_ready && !i_flush) |=> (o_out_valid && $stable(r_res)));

endmodule : seq_mag_comparator_ctrl
